// File: rtl/dmem_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | dmem_stage: ALU-addressed 2^AW x DW data RAM, valid/ready request + load response. |
// | Optional DMEM_CLEAR_EN zeroes the RAM after every reset.        Revision: 1.0     |
// +-----------------------------------------------------------------------------------+
module dmem_stage #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_we,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_wdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      RESP  = 2'd2
`ifdef DMEM_CLEAR_EN
      , CLEAR = 2'd3
`endif
   } state_t;

`ifdef DMEM_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
   localparam logic   RST_READY = 1'b0;
`else
   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_READY = 1'b1;
`endif

   logic [DW-1:0] mem [0:(1<<AW)-1];

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_rdata_q, out_rdata_d;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
`ifdef DMEM_CLEAR_EN
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      out_valid_d = out_valid_q;
      out_rdata_d = out_rdata_q;
      mem_we      = 1'b0;
      mem_waddr   = in_addr;
      mem_wdata   = in_wdata;
`ifdef DMEM_CLEAR_EN
      clr_cnt_d   = clr_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in_we) begin
                  mem_we = 1'b1;
               end else begin
                  addr_d  = in_addr;
                  state_d = READ;
               end
            end
         end
         READ: begin
            out_rdata_d = mem[addr_q];
            out_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
`ifdef DMEM_CLEAR_EN
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
      // Reset wins over any write that would land on the same edge
      if (Reset) mem_we = 1'b0;
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= RST_STATE;
         addr_q      <= '0;
         in_ready_q  <= RST_READY;
         out_valid_q <= 1'b0;
         out_rdata_q <= '0;
`ifdef DMEM_CLEAR_EN
         clr_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_rdata_q <= out_rdata_d;
`ifdef DMEM_CLEAR_EN
         clr_cnt_q   <= clr_cnt_d;
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_rdata = out_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_stage.sv
`default_nettype none
// tb_dmem_stage: directed and randomized checks of dmem_stage against an array reference model.
module tb_dmem_stage;
   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;
`ifdef DMEM_CLEAR_EN
   localparam logic RST_READY = 1'b0;
`else
   localparam logic RST_READY = 1'b1;
`endif

   logic          Clk = 1'b0;
   logic          Reset;
   logic          in_valid;
   logic          in_ready;
   logic          in_we;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_wdata;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_rdata;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] model [DEPTH];

   dmem_stage #(.AW(AW), .DW(DW)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_we     (in_we),
      .in_addr   (in_addr),
      .in_wdata  (in_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rdata (out_rdata)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (in_valid === 1'b1) begin
         assert (!$isunknown(in_we)) else begin
            errors++;
            $error("FAIL in_we_unknown: observed %b required 0/1", in_we);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
`ifdef DMEM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
   endtask

   task automatic wait_ready();
      int c;
      c = 0;
      while (in_ready !== 1'b1 && c < 1000) begin
         @(negedge Clk);
         c++;
      end
      if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wait_ready();
      in_valid = 1'b1; in_we = 1'b1; in_addr = a; in_wdata = d;
      @(negedge Clk);
      in_valid = 1'b0; in_we = 1'b0;
      model[a] = d;
   endtask

   // Issue a load, check 2-cycle latency, stall for 'stall' cycles while a
   // store is held pending (it must not be consumed), then retire.
   task automatic do_load(input logic [AW-1:0] a, input int stall, input string tag);
      logic [DW-1:0] exp;
      wait_ready();
      exp = model[a];
      in_valid = 1'b1; in_we = 1'b0; in_addr = a; in_wdata = DW'($urandom);
      @(negedge Clk);
      in_valid = 1'b0;
      check({tag, "_e0_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_e0_ready"}, 32'(in_ready), 32'd0);
      @(negedge Clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_rdata), 32'(exp));
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; in_we = 1'b1; in_addr = a; in_wdata = ~exp;
         @(negedge Clk);
         check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_stall_data"}, 32'(out_rdata), 32'(exp));
         check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge Clk);
      out_ready = 1'b0; in_valid = 1'b0; in_we = 1'b0;
      check({tag, "_ret_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_ret_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_ret_hold"}, 32'(out_rdata), 32'(exp));
   endtask

   initial begin
      int c;
      Reset = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_addr = '0; in_wdata = '0; out_ready = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_rdata", 32'(out_rdata), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'(RST_READY));
      Reset = 1'b0;
      reset_model();

      for (int i = 0; i < DEPTH; i++) do_store(AW'(i), DW'($urandom));
      check("fill_ready", 32'(in_ready), 32'd1);

      // store then load next cycle to the same address
      do_store(8'h08, 8'h05);
      do_load(8'h08, 0, "st_ld");
      do_load(8'h08, 5, "stall5");
      do_load(8'h08, 0, "after_stall");

      do_store(8'h00, 8'hAA);
      check("b2b_ready0", 32'(in_ready), 32'd1);
      do_store(8'h01, 8'h55);
      check("b2b_ready1", 32'(in_ready), 32'd1);
      do_store(8'hFF, 8'h3C);
      check("b2b_ready2", 32'(in_ready), 32'd1);
      do_load(8'h00, 0, "b2b_ld0");
      do_load(8'h01, 1, "b2b_ld1");
      do_load(8'hFF, 0, "b2b_ldff");

      // reset while the load is in READ
      wait_ready();
      in_valid = 1'b1; in_we = 1'b0; in_addr = 8'h08;
      @(negedge Clk);
      in_valid = 1'b0; Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      reset_model();
      check("rst_read_valid", 32'(out_valid), 32'd0);
      check("rst_read_ready", 32'(in_ready), 32'(RST_READY));
      repeat (3) @(negedge Clk);
      check("rst_read_valid_later", 32'(out_valid), 32'd0);

      // reset while the response is pending
      do_store(8'h08, 8'h5A);
      wait_ready();
      in_valid = 1'b1; in_we = 1'b0; in_addr = 8'h08;
      @(negedge Clk);
      in_valid = 1'b0;
      @(negedge Clk);
      check("rst_resp_pre_valid", 32'(out_valid), 32'd1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      reset_model();
      check("rst_resp_valid", 32'(out_valid), 32'd0);
      check("rst_resp_rdata", 32'(out_rdata), 32'd0);

      // store on the same edge as reset must be dropped
      do_store(8'h10, 8'h00);
      wait_ready();
      Reset = 1'b1; in_valid = 1'b1; in_we = 1'b1; in_addr = 8'h10; in_wdata = 8'h77;
      @(negedge Clk);
      Reset = 1'b0; in_valid = 1'b0; in_we = 1'b0;
      reset_model();
      do_load(8'h10, 0, "rst_store");

`ifdef DMEM_CLEAR_EN
      do_store(8'h20, 8'h99);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      reset_model();
      c = 0;
      while (in_ready !== 1'b1 && c < 1000) begin
         c++;
         @(negedge Clk);
      end
      check("clear_cycles", 32'(c), 32'd256);
      do_load(8'h20, 0, "clear_ld");
`endif

      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom);
         if ($urandom_range(0, 1) == 0) do_store(a, DW'($urandom));
         else do_load(a, int'($urandom_range(0, 3)), "rand_ld");
      end
      c = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
